// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one logic unit between two requesters; gnt at +1, done/result at +2, one op per 2 cycles.
// Optional ALU_ARB_LOCK_EN adds lock0/lock1 to park the arbiter on a locking requester.
module alu_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [1:0]       op0,
  input  logic [1:0]       op1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
`ifdef ALU_ARB_LOCK_EN
  input  logic             lock0,
  input  logic             lock1,
`endif
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic [1:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_y
);

  typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

  state_t           state_q, state_d;
  logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic             done0_q, done0_d, done1_q, done1_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [1:0]       alu_op_q, alu_op_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic             r0, r1, win_vld, win_sel;
`ifdef ALU_ARB_LOCK_EN
  logic             park_q, park_d;
  logic             hold_q, hold_d;
  logic             parked_now;
`endif

  always_comb begin
    state_d  = state_q;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    result_d = result_q;
    alu_op_d = alu_op_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    owner_d  = owner_q;
    last_d   = last_q;
    r0       = req0;
    r1       = req1;
`ifdef ALU_ARB_LOCK_EN
    park_d     = park_q;
    hold_d     = hold_q;
    // Park holds only while the owner keeps its lock; a dropped lock releases on this same edge.
    parked_now = park_q && (owner_q ? lock1 : lock0);
    if (parked_now) begin
      r0 = req0 & ~owner_q;
      r1 = req1 & owner_q;
    end
`endif
    win_vld = r0 | r1;
    win_sel = (r0 & r1) ? ~last_q : r1;

    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d  = EXEC;
          owner_d  = win_sel;
          gnt0_d   = ~win_sel;
          gnt1_d   = win_sel;
          alu_op_d = win_sel ? op1 : op0;
          alu_a_d  = win_sel ? a1 : a0;
          alu_b_d  = win_sel ? b1 : b0;
`ifdef ALU_ARB_LOCK_EN
          park_d = win_sel ? lock1 : lock0;
          hold_d = parked_now;
`endif
        end else begin
`ifdef ALU_ARB_LOCK_EN
          park_d = parked_now;
`endif
        end
      end
      EXEC: begin
        state_d  = IDLE;
        result_d = alu_y;
        done0_d  = ~owner_q;
        done1_d  = owner_q;
`ifdef ALU_ARB_LOCK_EN
        if (!hold_q) last_d = owner_q;
`else
        last_d = owner_q;
`endif
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == EXEC);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      busy_q   <= 1'b0;
      result_q <= '0;
      alu_op_q <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
`ifdef ALU_ARB_LOCK_EN
      park_q   <= 1'b0;
      hold_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      busy_q   <= busy_d;
      result_q <= result_d;
      alu_op_q <= alu_op_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
`ifdef ALU_ARB_LOCK_EN
      park_q   <= park_d;
      hold_q   <= hold_d;
`endif
    end
  end

  assign gnt0   = gnt0_q;
  assign gnt1   = gnt1_q;
  assign done0  = done0_q;
  assign done1  = done1_q;
  assign busy   = busy_q;
  assign result = result_q;
  assign alu_op = alu_op_q;
  assign alu_a  = alu_a_q;
  assign alu_b  = alu_b_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural model of the shared logic unit.
module tb_alu_arbiter;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0, req1;
  logic [1:0]       op0, op1;
  logic [WIDTH-1:0] a0, b0, a1, b1;
  logic             gnt0, gnt1, done0, done1, busy;
  logic [WIDTH-1:0] result, alu_a, alu_b, alu_y;
  logic [1:0]       alu_op;
`ifdef ALU_ARB_LOCK_EN
  logic             lock0, lock1;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Shared NAND-built unit: purely combinational on the arbiter's registered outputs.
  always_comb begin
    case (alu_op)
      2'b00:   alu_y = alu_a & alu_b;
      2'b01:   alu_y = ~(alu_a & alu_b);
      2'b10:   alu_y = alu_a | alu_b;
      default: alu_y = alu_a ^ alu_b;
    endcase
  end

  alu_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
`ifdef ALU_ARB_LOCK_EN
    .lock0(lock0), .lock1(lock1),
`endif
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result(result), .busy(busy),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Packs the pulse outputs as {gnt1, gnt0, done1, done0, busy}.
  function automatic logic [4:0] pulses();
    return {gnt1, gnt0, done1, done0, busy};
  endfunction

  initial begin
    rst = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    op0 = 2'b01; a0 = 8'hFF; b0 = 8'h0F;
    op1 = 2'b11; a1 = 8'hAA; b1 = 8'h55;
`ifdef ALU_ARB_LOCK_EN
    lock0 = 1'b0; lock1 = 1'b0;
`endif

    // Reset held two cycles with both requests high
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_pulses", pulses(), 5'b0);
      check("rst_result", result, 0);
      check("rst_alu", {alu_op, alu_a, alu_b}, 0);
    end
    rst = 1'b0;

    // Tie after reset: req0 first, then strict alternation
    step();
    check("tie_gnt", pulses(), 5'b01001);
    check("tie_alu", {alu_op, alu_a, alu_b}, {2'b01, 8'hFF, 8'h0F});
    step();
    check("tie_done0", pulses(), 5'b00010);
    check("tie_res0", result, 8'hF0);
    step();
    check("tie_gnt1", pulses(), 5'b10001);
    step();
    check("tie_done1", pulses(), 5'b00100);
    check("tie_res1", result, 8'hFF);
    step();
    check("tie_gnt0b", pulses(), 5'b01001);
    step();
    check("tie_done0b", pulses(), 5'b00010);
    check("tie_res0b", result, 8'hF0);
    step();
    check("tie_gnt1b", pulses(), 5'b10001);
    req0 = 1'b0; req1 = 1'b0;
    step();
    check("tie_done1b", pulses(), 5'b00100);
    step();
    check("idle_quiet", pulses(), 5'b0);
    check("result_hold", result, 8'hFF);

    // Single op on requester 0
    req0 = 1'b1; op0 = 2'b00; a0 = 8'hF0; b0 = 8'h3C;
    step();
    check("single_gnt", pulses(), 5'b01001);
    check("single_alu", {alu_op, alu_a}, {2'b00, 8'hF0});
    req0 = 1'b0;
    step();
    check("single_done", pulses(), 5'b00010);
    check("single_res", result, 8'h30);

    // Streaming requester 1 for six cycles
    req1 = 1'b1; op1 = 2'b10; a1 = 8'h0C; b1 = 8'h03;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c % 2 == 1) check($sformatf("stream_gnt%0d", c), pulses(), 5'b10001);
      else begin
        check($sformatf("stream_done%0d", c), pulses(), 5'b00100);
        check($sformatf("stream_res%0d", c), result, 8'h0F);
      end
    end
    req1 = 1'b0;
    step();
    check("stream_end", pulses(), 5'b0);

    // Reset during EXEC aborts the operation
    req0 = 1'b1; op0 = 2'b11; a0 = 8'h0F; b0 = 8'hF0;
    step();
    check("abort_gnt", pulses(), 5'b01001);
    req0 = 1'b0; rst = 1'b1;
    step();
    check("abort_pulses", pulses(), 5'b0);
    check("abort_result", result, 0);
    check("abort_alu", {alu_op, alu_a, alu_b}, 0);
    rst = 1'b0;
    step();
    check("abort_nodone", pulses(), 5'b0);

    // After reset, last favours requester 0 on a tie
    req0 = 1'b1; req1 = 1'b1;
    step();
    check("post_rst_tie", pulses(), 5'b01001);
    req0 = 1'b0; req1 = 1'b0;
    step();
    check("post_rst_done", pulses(), 5'b00010);
    check("post_rst_res", result, 8'hFF);

`ifdef ALU_ARB_LOCK_EN
    // Lock parks on requester 0 for three grants, then releases to requester 1
    rst = 1'b1;
    step();
    rst = 1'b0;
    req0 = 1'b1; req1 = 1'b1; lock0 = 1'b1;
    for (int g = 0; g < 3; g++) begin
      step();
      check($sformatf("lock_gnt%0d", g), pulses(), 5'b01001);
      if (g == 2) lock0 = 1'b0;
      step();
      check($sformatf("lock_done%0d", g), pulses(), 5'b00010);
    end
    step();
    check("lock_release", pulses(), 5'b10001);
    req0 = 1'b0; req1 = 1'b0;
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
